// File: rtl/demux_reg_bank_4x4.sv
// demux_reg_bank_4x4
//
// Registered 1:4 write demultiplexer feeding four 4-bit registers (a, b, c, d).
// A write is accepted under a valid/ready handshake. The destination and data are
// held for one cycle (HOLD) while a one-hot strobe addresses the target register.
// The register loads at the edge ending HOLD, and wr_done pulses in the following cycle.
//
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous active-high reset
//   wr_valid   in  write request present
//   wr_ready   out request can be accepted this cycle
//   sel1/sel0  in  destination select {sel1, sel0}: 00=a 01=b 10=c 11=d
//   din        in  write data
//   clr        in  synchronous clear of all four registers
//   en_onehot  out write strobe {d,c,b,a}, nonzero only in HOLD
//   wr_done    out one-cycle pulse after a committed write
//   q_a..q_d   out register contents
module demux_reg_bank_4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       sel1,
  input  logic       sel0,
  input  logic [3:0] din,
  input  logic       clr,
  output logic [3:0] en_onehot,
  output logic       wr_done,
  output logic [3:0] q_a,
  output logic [3:0] q_b,
  output logic [3:0] q_c,
  output logic [3:0] q_d
);

  localparam logic StIdle = 1'b0;
  localparam logic StHold = 1'b1;

  logic       state_q, state_d;
  logic [1:0] sel_h_q, sel_h_d;
  logic [3:0] din_h_q, din_h_d;
  logic       wr_done_q, wr_done_d;
  logic [3:0] q_a_q, q_a_d;
  logic [3:0] q_b_q, q_b_d;
  logic [3:0] q_c_q, q_c_d;
  logic [3:0] q_d_q, q_d_d;
  logic       accept;

  assign wr_ready = (state_q == StIdle) & ~clr & ~rst;
  assign accept   = wr_valid & wr_ready;

  always_comb begin
    en_onehot = 4'b0000;
    if (state_q == StHold) begin
      unique case (sel_h_q)
        2'b00: en_onehot = 4'b0001;
        2'b01: en_onehot = 4'b0010;
        2'b10: en_onehot = 4'b0100;
        2'b11: en_onehot = 4'b1000;
        default: en_onehot = 4'b0000;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_h_d   = sel_h_q;
    din_h_d   = din_h_q;
    wr_done_d = 1'b0;
    q_a_d     = q_a_q;
    q_b_d     = q_b_q;
    q_c_d     = q_c_q;
    q_d_d     = q_d_q;

    if (clr) begin
      // Clear wins over a pending commit: the held write is dropped.
      state_d = StIdle;
      q_a_d   = 4'h0;
      q_b_d   = 4'h0;
      q_c_d   = 4'h0;
      q_d_d   = 4'h0;
    end else if (state_q == StHold) begin
      if (en_onehot[0]) q_a_d = din_h_q;
      if (en_onehot[1]) q_b_d = din_h_q;
      if (en_onehot[2]) q_c_d = din_h_q;
      if (en_onehot[3]) q_d_d = din_h_q;
      wr_done_d = 1'b1;
      state_d   = StIdle;
    end else if (accept) begin
      sel_h_d = {sel1, sel0};
      din_h_d = din;
      state_d = StHold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_h_q   <= 2'b00;
      din_h_q   <= 4'h0;
      wr_done_q <= 1'b0;
      q_a_q     <= 4'h0;
      q_b_q     <= 4'h0;
      q_c_q     <= 4'h0;
      q_d_q     <= 4'h0;
    end else begin
      state_q   <= state_d;
      sel_h_q   <= sel_h_d;
      din_h_q   <= din_h_d;
      wr_done_q <= wr_done_d;
      q_a_q     <= q_a_d;
      q_b_q     <= q_b_d;
      q_c_q     <= q_c_d;
      q_d_q     <= q_d_d;
    end
  end

  assign wr_done = wr_done_q;
  assign q_a     = q_a_q;
  assign q_b     = q_b_q;
  assign q_c     = q_c_q;
  assign q_d     = q_d_q;

endmodule

// File: tb/tb_demux_reg_bank_4x4.sv
// Testbench for demux_reg_bank_4x4: a directed vector table, followed by randomized
// traffic checked against a behavioural model of the register bank.
module tb_demux_reg_bank_4x4;

  logic       clk = 1'b0;
  logic       rst, wr_valid, sel1, sel0, clr;
  logic [3:0] din;
  logic       wr_ready, wr_done;
  logic [3:0] en_onehot, q_a, q_b, q_c, q_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_reg_bank_4x4 dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .sel1      (sel1),
    .sel0      (sel0),
    .din       (din),
    .clr       (clr),
    .en_onehot (en_onehot),
    .wr_done   (wr_done),
    .q_a       (q_a),
    .q_b       (q_b),
    .q_c       (q_c),
    .q_d       (q_d)
  );

  // Inputs applied during a cycle and the outputs expected in that same cycle.
  typedef struct packed {
    logic        rst;
    logic        clr;
    logic        valid;
    logic [1:0]  sel;
    logic [3:0]  din;
    logic        rdy;
    logic [3:0]  en;
    logic        done;
    logic [15:0] q;  // {d, c, b, a}
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: register array plus an optional pending write.
  logic [3:0] m_mem[4];
  bit         m_pending;
  int         m_idx;
  logic [3:0] m_data;
  bit         m_done;

  function automatic vec_t mk(logic r, logic c, logic v, logic [1:0] s, logic [3:0] d,
                              logic rdy, logic [3:0] en, logic done, logic [15:0] q);
    vec_t t;
    t = '{rst: r, clr: c, valid: v, sel: s, din: d, rdy: rdy, en: en, done: done, q: q};
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic v, input logic [1:0] s,
                       input logic [3:0] d);
    rst = r; clr = c; wr_valid = v; {sel1, sel0} = s; din = d;
    #1;
  endtask

  // Advance the model by one edge using the currently driven inputs, then move the DUT.
  task automatic step();
    if (rst) begin
      for (int i = 0; i < 4; i++) m_mem[i] = 4'h0;
      m_pending = 0; m_done = 0; m_idx = 0; m_data = 4'h0;
    end else begin
      m_done = 0;
      if (clr) begin
        for (int i = 0; i < 4; i++) m_mem[i] = 4'h0;
        m_pending = 0;
      end else if (m_pending) begin
        m_mem[m_idx] = m_data;
        m_done = 1;
        m_pending = 0;
      end else if (wr_valid) begin
        m_idx = int'({sel1, sel0});
        m_data = din;
        m_pending = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model();
    logic       exp_rdy;
    logic [3:0] exp_en;
    exp_rdy = !m_pending && !clr && !rst;
    exp_en  = m_pending ? 4'(1 << m_idx) : 4'b0000;
    check("rnd_ready", 16'(wr_ready), 16'(exp_rdy));
    check("rnd_en", 16'(en_onehot), 16'(exp_en));
    check("rnd_done", 16'(wr_done), 16'(m_done));
    check("rnd_q", {q_d, q_c, q_b, q_a}, {m_mem[3], m_mem[2], m_mem[1], m_mem[0]});
  endtask

  initial begin
    //                 rst clr v  sel    din    rdy en       done q
    vecs.push_back(mk(1, 0, 0, 2'b00, 4'h0, 0, 4'b0000, 0, 16'h0000));
    // Pattern fill a=A, b=5, c=A, d=5.
    vecs.push_back(mk(0, 0, 1, 2'b00, 4'hA, 1, 4'b0000, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 0, 4'b0001, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 2'b01, 4'h5, 1, 4'b0000, 1, 16'h000A));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 0, 4'b0010, 0, 16'h000A));
    vecs.push_back(mk(0, 0, 1, 2'b10, 4'hA, 1, 4'b0000, 1, 16'h005A));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 0, 4'b0100, 0, 16'h005A));
    vecs.push_back(mk(0, 0, 1, 2'b11, 4'h5, 1, 4'b0000, 1, 16'h0A5A));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 0, 4'b1000, 0, 16'h0A5A));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 1, 4'b0000, 1, 16'h5A5A));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 1, 4'b0000, 0, 16'h5A5A));
    // Back-to-back with wr_valid held: d=3, a=C, b=6, c=9.
    vecs.push_back(mk(0, 0, 1, 2'b11, 4'h3, 1, 4'b0000, 0, 16'h5A5A));
    vecs.push_back(mk(0, 0, 1, 2'b11, 4'h3, 0, 4'b1000, 0, 16'h5A5A));
    vecs.push_back(mk(0, 0, 1, 2'b00, 4'hC, 1, 4'b0000, 1, 16'h3A5A));
    vecs.push_back(mk(0, 0, 1, 2'b00, 4'hC, 0, 4'b0001, 0, 16'h3A5A));
    vecs.push_back(mk(0, 0, 1, 2'b01, 4'h6, 1, 4'b0000, 1, 16'h3A5C));
    vecs.push_back(mk(0, 0, 1, 2'b01, 4'h6, 0, 4'b0010, 0, 16'h3A5C));
    vecs.push_back(mk(0, 0, 1, 2'b10, 4'h9, 1, 4'b0000, 1, 16'h3A6C));
    vecs.push_back(mk(0, 0, 1, 2'b10, 4'h9, 0, 4'b0100, 0, 16'h3A6C));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 1, 4'b0000, 1, 16'h396C));
    // Clear during HOLD of b=F: write dropped, all registers zero, no done.
    vecs.push_back(mk(0, 0, 1, 2'b01, 4'hF, 1, 4'b0000, 0, 16'h396C));
    vecs.push_back(mk(0, 1, 0, 2'b00, 4'h0, 0, 4'b0010, 0, 16'h396C));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 1, 4'b0000, 0, 16'h0000));
    // Clear blocks an IDLE request; accepted the next cycle.
    vecs.push_back(mk(0, 1, 1, 2'b10, 4'h7, 0, 4'b0000, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 2'b10, 4'h7, 1, 4'b0000, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 0, 4'b0100, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 1, 4'b0000, 1, 16'h0700));
    // Reset during HOLD of d=E.
    vecs.push_back(mk(0, 0, 1, 2'b11, 4'hE, 1, 4'b0000, 0, 16'h0700));
    vecs.push_back(mk(1, 0, 0, 2'b00, 4'h0, 0, 4'b1000, 0, 16'h0700));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 1, 4'b0000, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 2'b00, 4'h0, 1, 4'b0000, 0, 16'h0000));

    // Preliminary reset edge so the first table row sees a defined state.
    drive(1, 0, 0, 2'b00, 4'h0);
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].valid, vecs[i].sel, vecs[i].din);
      check($sformatf("vec%0d_ready", i), 16'(wr_ready), 16'(vecs[i].rdy));
      check($sformatf("vec%0d_en", i), 16'(en_onehot), 16'(vecs[i].en));
      check($sformatf("vec%0d_done", i), 16'(wr_done), 16'(vecs[i].done));
      check($sformatf("vec%0d_q", i), {q_d, q_c, q_b, q_a}, vecs[i].q);
      step();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(31) == 0), ($urandom_range(7) == 0), 1'($urandom_range(1)),
            2'($urandom_range(3)), 4'($urandom_range(15)));
      check_model();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_reg_bank_4x4.md
# demux_reg_bank_4x4

Write-side companion to the 4:1 read mux: a registered 1:4 demultiplexer feeding a bank of four 4-bit registers (a, b, c, d). It accepts one write request under a valid/ready handshake and decodes `{sel1, sel0}` into a one-hot write strobe. It commits the data into the addressed register one cycle later and pulses a completion flag. The outputs `q_a`..`q_d` drive the data inputs of the four per-bit 4:1 mux slices in the CPU register path.

## Interface
- No parameters; widths are fixed: 4 registers × 4 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `wr_valid` in 1: write request present.
- `wr_ready` out 1: block can accept a request this cycle.
- `sel1` in 1: destination select MSB; sampled on accept.
- `sel0` in 1: destination select LSB; sampled on accept.
- `din` in 4: write data; sampled on accept.
- `clr` in 1: synchronous clear of all four registers.
- `en_onehot` out 4: write strobe {d,c,b,a}; nonzero only in HOLD.
- `wr_done` out 1: one-cycle pulse after a committed write.
- `q_a`, `q_b`, `q_c`, `q_d` out 4 each: register contents.

## Operation
- Two-state FSM: IDLE, HOLD.
- Accept condition: `wr_valid & wr_ready` at a rising edge.
- IDLE:
  - `wr_ready = !clr & !rst`.
  - On accept: capture `{sel1, sel0}` into `sel_h` and `din` into `din_h`, then go to HOLD.
  - With no accept, stay in IDLE.
- HOLD:
  - `wr_ready = 0`.
  - `en_onehot` decodes `sel_h`: 00→0001 (a), 01→0010 (b), 10→0100 (c), 11→1000 (d).
  - At the edge ending HOLD, the strobed register loads `din_h`, `wr_done` is set for the next cycle, and the FSM returns to IDLE unconditionally.
- `en_onehot` is 0000 in IDLE.
- Exactly one register changes per committed write; the other three hold.
- `clr`:
  - At the next edge, all `q_*` become 0.
  - `clr` has priority over a HOLD commit: the pending write is discarded, `wr_done` stays 0, and the FSM goes to IDLE.
  - In IDLE, `clr` forces `wr_ready = 0`, so no request is accepted that cycle.
- `rst`:
  - At the next edge: FSM to IDLE, all `q_*` = 0, `sel_h` = 0, `din_h` = 0, `wr_done` = 0.
  - Overrides `clr` and any pending write.
  - `wr_ready = 0` while `rst` is high.
- Values of `wr_valid`, `sel`, and `din` outside the accept edge are ignored.
- The requester must hold `sel` and `din` stable while `wr_valid` is high and `wr_ready` is low.

## Timing
- Request accepted at the edge ending cycle t:
  - Cycle t+1: HOLD, `en_onehot` valid, `wr_ready` = 0.
  - Edge ending t+1: target register loads.
  - Cycle t+2: new `q_*` visible, `wr_done` = 1, `wr_ready` = 1 (if `!clr`).
- Write latency: 2 edges from accept to visible data.
- Throughput: 1 write per 2 cycles.
  - With `wr_valid` held high, accepts occur at the edges ending t, t+2, t+4, …
- `wr_done` is high for exactly one cycle per commit and is registered.
- `wr_ready` and `en_onehot` are combinational from state, `sel_h`, `clr`, and `rst`.
- Reset values:
  - `q_a`..`q_d` = 0000, `wr_done` = 0, `en_onehot` = 0000.
  - `wr_ready` = 0 while `rst` is high, then 1 in the first cycle after `rst` is released.

## Test plan
- Reset then idle: assert `rst` for 2 cycles → all `q_*` = 0, `wr_done` = 0, `en_onehot` = 0000. After release, `wr_ready` = 1.
- Pattern 1010 fill:
  - Write a=4'hA (00), b=4'h5 (01), c=4'hA (10), d=4'h5 (11) as separate handshakes.
  - Each commit: `en_onehot` 0001/0010/0100/1000 during HOLD, `wr_done` pulse 2 edges after accept, only the target register changes.
  - Final state: A, 5, A, 5.
- Back-to-back: hold `wr_valid` = 1 across four requests (d=4'h3, a=4'hC, b=4'h6, c=4'h9) → accepts every 2nd edge, `wr_ready` alternates 1/0, four `wr_done` pulses, `q` = C, 6, 9, 3.
- Clear during HOLD: accept b=4'hF, assert `clr` in the HOLD cycle → `q_b` = 0 (not F), all `q_*` = 0, no `wr_done`, FSM in IDLE.
- Clear vs request in IDLE: `clr` = 1 with `wr_valid` = 1, `sel` = 10, `din` = 4'h7 → `wr_ready` = 0, no accept. With `clr` = 0 the next cycle, accept occurs and `q_c` = 7 two edges later.
- Reset mid-operation: accept d=4'hE, assert `rst` in HOLD → `q_d` = 0, `wr_done` never pulses, `wr_ready` = 1 after release.
